// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register, data-memory access sequencer and MEM/WB register
// for the 5-stage MIPS pipeline.
//
// state  | meaning
// S_IDLE | new EX/MEM contents; aligned lw/sw requests memory this cycle
// S_WAIT | request outstanding, counting towards TIMEOUT
module ex_mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int PC_W    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            EX_flush,
  input  logic            EX_regwrite,
  input  logic            EX_memtoreg,
  input  logic            EX_memread,
  input  logic            EX_memwrite,
  input  logic            EX_link,
  input  logic [4:0]      EX_wraddr,
  input  logic [31:0]     EX_alu_res,
  input  logic [31:0]     EX_data2,
  input  logic [PC_W-1:0] EX_pc_4,
  output logic            MEM_regwrite,
  output logic            MEM_memread,
  output logic [4:0]      MEM_wraddr,
  output logic [31:0]     MEM_alu_res,
  output logic            mem_stall,
  output logic            dm_req,
  output logic            dm_we,
  output logic [29:0]     dm_addr,
  output logic [31:0]     dm_wdata,
  input  logic [31:0]     dm_rdata,
  input  logic            dm_ack,
  output logic            WB_regwrite,
  output logic            WB_memtoreg,
  output logic            WB_link,
  output logic [4:0]      WB_wraddr,
  output logic [31:0]     WB_alu_res,
  output logic [31:0]     WB_memdata,
  output logic [PC_W-1:0] WB_pc_4,
  output logic            mem_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [7:0] CNT_TC = 8'(TIMEOUT - 1);

  logic            regwrite_q, memtoreg_q, memread_q, memwrite_q, link_q;
  logic [4:0]      wraddr_q;
  logic [31:0]     alu_res_q, data2_q;
  logic [PC_W-1:0] pc_4_q;

  logic [0:0]      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            done_q, done_d;

  logic            wb_regwrite_q, wb_memtoreg_q, wb_link_q;
  logic [4:0]      wb_wraddr_q;
  logic [31:0]     wb_alu_res_q, wb_memdata_q;
  logic [PC_W-1:0] wb_pc_4_q;

  logic memop, misalign, issue, req, ack, timeout_hit, stall;

  assign memop       = memread_q | memwrite_q;
  assign misalign    = memop & (alu_res_q[1:0] != 2'b00);
  assign issue       = memop & ~misalign & ~done_q;
  assign req         = (state_q == S_WAIT) | ((state_q == S_IDLE) & issue);
  assign ack         = dm_ack & req;
  assign timeout_hit = (state_q == S_WAIT) & ~dm_ack & (cnt_q == CNT_TC);
  assign stall       = req & ~dm_ack & ~timeout_hit;

  // EX/MEM register: frozen while the memory access is outstanding
  always_ff @(posedge clk) begin
    if (rst_n) begin
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      link_q     <= 1'b0;
      wraddr_q   <= '0;
      alu_res_q  <= '0;
      data2_q    <= '0;
      pc_4_q     <= '0;
    end else if (!stall) begin
      regwrite_q <= EX_regwrite & ~EX_flush;
      memtoreg_q <= EX_memtoreg & ~EX_flush;
      memread_q  <= EX_memread  & ~EX_flush;
      memwrite_q <= EX_memwrite & ~EX_flush;
      link_q     <= EX_link     & ~EX_flush;
      wraddr_q   <= EX_flush ? '0 : EX_wraddr;
      alu_res_q  <= EX_flush ? '0 : EX_alu_res;
      data2_q    <= EX_flush ? '0 : EX_data2;
      pc_4_q     <= EX_flush ? '0 : EX_pc_4;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (issue && !dm_ack) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (issue) begin
          done_d = 1'b1;
        end
      end
      default: begin
        if (dm_ack || timeout_hit) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
    // a fresh EX/MEM value always restarts the sequencer
    if (!stall) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // MEM/WB register: bubble while stalled, squash writeback on error
  always_ff @(posedge clk) begin
    if (rst_n || stall) begin
      wb_regwrite_q <= 1'b0;
      wb_memtoreg_q <= 1'b0;
      wb_link_q     <= 1'b0;
      wb_wraddr_q   <= '0;
      wb_alu_res_q  <= '0;
      wb_memdata_q  <= '0;
      wb_pc_4_q     <= '0;
    end else begin
      wb_regwrite_q <= regwrite_q & ~misalign & ~timeout_hit;
      wb_memtoreg_q <= memtoreg_q;
      wb_link_q     <= link_q;
      wb_wraddr_q   <= wraddr_q;
      wb_alu_res_q  <= alu_res_q;
      wb_memdata_q  <= (memread_q & ack) ? dm_rdata : '0;
      wb_pc_4_q     <= pc_4_q;
    end
  end

  assign MEM_regwrite = regwrite_q;
  assign MEM_memread  = memread_q;
  assign MEM_wraddr   = wraddr_q;
  assign MEM_alu_res  = alu_res_q;
  assign mem_stall    = stall;
  assign dm_req       = req;
  assign dm_we        = memwrite_q;
  assign dm_addr      = alu_res_q[31:2];
  assign dm_wdata     = data2_q;
  assign mem_err      = misalign | timeout_hit;

  assign WB_regwrite  = wb_regwrite_q;
  assign WB_memtoreg  = wb_memtoreg_q;
  assign WB_link      = wb_link_q;
  assign WB_wraddr    = wb_wraddr_q;
  assign WB_alu_res   = wb_alu_res_q;
  assign WB_memdata   = wb_memdata_q;
  assign WB_pc_4      = wb_pc_4_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed vector table, randomized instruction stream
// checked against a transaction-level latency model, and reset mid-access.
module tb_ex_mem_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EX_flush, EX_regwrite, EX_memtoreg, EX_memread, EX_memwrite, EX_link;
  logic [4:0]  EX_wraddr;
  logic [31:0] EX_alu_res, EX_data2;
  logic [8:0]  EX_pc_4;
  logic        MEM_regwrite, MEM_memread;
  logic [4:0]  MEM_wraddr;
  logic [31:0] MEM_alu_res;
  logic        mem_stall, dm_req, dm_we;
  logic [29:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic        dm_ack;
  logic        WB_regwrite, WB_memtoreg, WB_link;
  logic [4:0]  WB_wraddr;
  logic [31:0] WB_alu_res, WB_memdata;
  logic [8:0]  WB_pc_4;
  logic        mem_err;

  ex_mem_stage #(.TIMEOUT(TO), .PC_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .EX_flush(EX_flush), .EX_regwrite(EX_regwrite),
    .EX_memtoreg(EX_memtoreg), .EX_memread(EX_memread), .EX_memwrite(EX_memwrite),
    .EX_link(EX_link), .EX_wraddr(EX_wraddr), .EX_alu_res(EX_alu_res),
    .EX_data2(EX_data2), .EX_pc_4(EX_pc_4), .MEM_regwrite(MEM_regwrite),
    .MEM_memread(MEM_memread), .MEM_wraddr(MEM_wraddr), .MEM_alu_res(MEM_alu_res),
    .mem_stall(mem_stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .WB_regwrite(WB_regwrite), .WB_memtoreg(WB_memtoreg), .WB_link(WB_link),
    .WB_wraddr(WB_wraddr), .WB_alu_res(WB_alu_res), .WB_memdata(WB_memdata),
    .WB_pc_4(WB_pc_4), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl, rw, mtr, mr, mw, lk;
    logic [4:0]  wa;
    logic [31:0] alu, d2;
    logic [8:0]  pc;
    int          lat;       // cycles from request to ack
    logic [31:0] rd;
    int          exp_stall;
    logic        exp_err, exp_req, exp_wbrw;
    logic [31:0] exp_md;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   idx     = 0;
  vec_t tbl[12];
  vec_t stream[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (instr %0d): got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(logic fl, rw, mtr, mr, mw, lk, logic [4:0] wa,
                              logic [31:0] alu, d2, logic [8:0] pc, int lat,
                              logic [31:0] rd, int st, logic err, req, wrw,
                              logic [31:0] md);
    vec_t v;
    v.fl = fl; v.rw = rw; v.mtr = mtr; v.mr = mr; v.mw = mw; v.lk = lk;
    v.wa = wa; v.alu = alu; v.d2 = d2; v.pc = pc; v.lat = lat; v.rd = rd;
    v.exp_stall = st; v.exp_err = err; v.exp_req = req; v.exp_wbrw = wrw; v.exp_md = md;
    return v;
  endfunction

  // Transaction view: an aligned access waits min(latency, TIMEOUT) cycles;
  // a latency beyond TIMEOUT is an abort, latency == TIMEOUT still completes.
  function automatic vec_t model(vec_t v);
    logic mem, mis, acc, done, abort;
    mem   = (v.mr | v.mw) & ~v.fl;
    mis   = mem & (v.alu[1:0] != 2'b00);
    acc   = mem & ~mis;
    done  = acc & (v.lat <= TO);
    abort = acc & (v.lat > TO);
    v.exp_req   = acc;
    v.exp_stall = !acc ? 0 : ((v.lat <= TO) ? v.lat : TO);
    v.exp_err   = mis | abort;
    v.exp_wbrw  = v.rw & ~v.fl & ~mis & ~abort;
    v.exp_md    = (v.mr & done) ? v.rd : 32'h0;
    return v;
  endfunction

  task automatic drive_ex(input vec_t v);
    EX_flush = v.fl; EX_regwrite = v.rw; EX_memtoreg = v.mtr; EX_memread = v.mr;
    EX_memwrite = v.mw; EX_link = v.lk; EX_wraddr = v.wa; EX_alu_res = v.alu;
    EX_data2 = v.d2; EX_pc_4 = v.pc;
  endtask

  task automatic drive_garbage();
    EX_flush = 1'($urandom); EX_regwrite = 1'($urandom); EX_memtoreg = 1'($urandom);
    EX_memread = 1'($urandom); EX_memwrite = 1'($urandom); EX_link = 1'($urandom);
    EX_wraddr = 5'($urandom); EX_alu_res = $urandom; EX_data2 = $urandom;
    EX_pc_4 = 9'($urandom);
  endtask

  // cur sits in EX/MEM on entry (posedge+1); nxt is presented on its last cycle
  task automatic mem_phase(input vec_t cur, input vec_t nxt);
    logic [31:0] e_alu, e_d2;
    logic [4:0]  e_wa;
    logic        e_mw, e_mr, e_rw;
    e_alu = cur.fl ? 32'h0 : cur.alu;
    e_d2  = cur.fl ? 32'h0 : cur.d2;
    e_wa  = cur.fl ? 5'h0 : cur.wa;
    e_mw  = cur.mw & ~cur.fl;
    e_mr  = cur.mr & ~cur.fl;
    e_rw  = cur.rw & ~cur.fl;
    for (int c = 0; c <= cur.exp_stall; c++) begin
      dm_ack   = cur.exp_req && (c == cur.lat);
      dm_rdata = dm_ack ? cur.rd : $urandom;
      if (c == cur.exp_stall) drive_ex(nxt);
      else drive_garbage();
      @(negedge clk);
      check("mem_stall", mem_stall, c < cur.exp_stall);
      check("dm_req", dm_req, cur.exp_req);
      check("mem_err", mem_err, (c == cur.exp_stall) && cur.exp_err);
      if (c == 0 || c == cur.exp_stall) begin
        check("dm_addr", dm_addr, e_alu[31:2]);
        check("dm_we", dm_we, e_mw);
        check("dm_wdata", dm_wdata, e_d2);
        check("MEM_fwd", {MEM_regwrite, MEM_memread, MEM_wraddr, MEM_alu_res},
              {e_rw, e_mr, e_wa, e_alu});
      end
      if (c > 0) check("WB_bubble", {WB_regwrite, WB_alu_res}, 33'h0);
      @(posedge clk); #1;
    end
    dm_ack = 1'b0;
    check("WB_regwrite", WB_regwrite, cur.exp_wbrw);
    check("WB_ctl", {WB_memtoreg, WB_link}, {cur.mtr & ~cur.fl, cur.lk & ~cur.fl});
    check("WB_wraddr", WB_wraddr, e_wa);
    check("WB_alu_res", WB_alu_res, e_alu);
    check("WB_pc_4", WB_pc_4, cur.fl ? 9'h0 : cur.pc);
    check("WB_memdata", WB_memdata, cur.exp_md);
  endtask

  task automatic run_stream();
    vec_t bub;
    bub = mk(0,0,0,0,0,0, 0, 0, 0, 0, 0, 0, 0, 0,0,0, 0);
    drive_ex(stream[0]);
    @(posedge clk); #1;
    for (int i = 0; i < stream.size(); i++) begin
      idx = i;
      mem_phase(stream[i], (i + 1 < stream.size()) ? stream[i+1] : bub);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   op;
    rst_n = 1'b1; dm_ack = 1'b0; dm_rdata = 32'h0;
    drive_ex(mk(0,0,0,0,0,0, 0, 0, 0, 0, 0, 0, 0, 0,0,0, 0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_state", {dm_req, mem_stall, mem_err, WB_regwrite, WB_alu_res, MEM_alu_res},
          68'h0);
    @(posedge clk); #1;

    //            fl rw mt mr mw lk wa  alu         d2            pc     lat rdata        st  er rq wr memdata
    tbl[0]  = mk(0, 1, 0, 0, 0, 0,  5, 32'h1234, 32'h0,        9'h004, 0, 32'h0,        0, 0, 0, 1, 32'h0);
    tbl[1]  = mk(0, 1, 1, 1, 0, 0,  8, 32'h40,   32'h0,        9'h008, 0, 32'hDEADBEEF, 0, 0, 1, 1, 32'hDEADBEEF);
    tbl[2]  = mk(0, 0, 0, 0, 1, 0,  0, 32'h80,   32'hA5A5A5A5, 9'h00C, 3, 32'h0,        3, 0, 1, 0, 32'h0);
    tbl[3]  = mk(0, 1, 1, 1, 0, 0, 10, 32'h100,  32'h0,        9'h010, 20, 32'h11112222, 16, 1, 1, 0, 32'h0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0,  9, 32'h77,   32'h5,        9'h014, 0, 32'h0,        0, 0, 0, 1, 32'h0);
    tbl[5]  = mk(0, 1, 1, 1, 0, 0, 11, 32'h42,   32'h0,        9'h018, 0, 32'h33,       0, 1, 0, 0, 32'h0);
    tbl[6]  = mk(1, 1, 1, 1, 0, 1, 12, 32'hFFFF, 32'h9,        9'h1FF, 0, 32'h0,        0, 0, 0, 0, 32'h0);
    tbl[7]  = mk(0, 1, 1, 1, 0, 0, 13, 32'h200,  32'h0,        9'h020, 16, 32'hCAFEF00D, 16, 0, 1, 1, 32'hCAFEF00D);
    tbl[8]  = mk(0, 1, 1, 1, 0, 0, 14, 32'h204,  32'h0,        9'h024, 15, 32'h0BADC0DE, 15, 0, 1, 1, 32'h0BADC0DE);
    tbl[9]  = mk(0, 0, 0, 0, 1, 0,  0, 32'h81,   32'h77,       9'h028, 0, 32'h0,        0, 1, 0, 0, 32'h0);
    tbl[10] = mk(0, 1, 0, 0, 0, 1, 31, 32'h0,    32'h0,        9'h1AB, 0, 32'h0,        0, 0, 0, 1, 32'h0);
    tbl[11] = mk(0, 1, 1, 1, 0, 0, 15, 32'h300,  32'h0,        9'h02C, 17, 32'h1,       16, 1, 1, 0, 32'h0);
    stream.delete();
    foreach (tbl[i]) stream.push_back(tbl[i]);
    run_stream();

    stream.delete();
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 3);
      v = mk(($urandom_range(0, 9) == 0), (op != 2), (op == 1), (op == 1), (op == 2), (op == 3),
             5'($urandom), $urandom, $urandom, 9'($urandom),
             ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, TO + 3),
             $urandom, 0, 0, 0, 0, 32'h0);
      if ($urandom_range(0, 3) != 0) v.alu[1:0] = 2'b00;
      stream.push_back(model(v));
    end
    run_stream();

    // reset in the middle of an outstanding load
    idx = -1;
    drive_ex(mk(0,1,1,1,0,0, 3, 32'h100, 0, 9'h40, 0, 0, 0, 0,0,0, 0));
    @(posedge clk); #1;
    drive_ex(mk(0,0,0,0,0,0, 0, 0, 0, 0, 0, 0, 0, 0,0,0, 0));
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst_pre_wait", {mem_stall, dm_req}, 2'b11);
    @(posedge clk); #1;
    rst_n = 1'b1; dm_ack = 1'b1; dm_rdata = 32'h5555AAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_req_stall", {dm_req, mem_stall, MEM_memread}, 3'b000);
    check("rst_wb", {WB_regwrite, WB_memtoreg, WB_link, WB_wraddr, WB_alu_res, WB_memdata, WB_pc_4},
          81'h0);
    @(posedge clk); #1;
    check("rst_ack_ignored", {WB_memdata, WB_regwrite}, 33'h0);
    dm_ack = 1'b0;

    stream.delete();
    stream.push_back(tbl[0]);
    stream.push_back(tbl[1]);
    run_stream();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline register plus data-memory access sequencer for the 5-stage MIPS pipeline.
- Captures EX results and control, runs lw/sw against a handshaked data memory, and feeds the MEM/WB register.
- Drives forwarding info to FWDPU and a stall to HZDPU while an access is outstanding.

Parameters:
TIMEOUT, 16, max cycles waiting for dm_ack before abort (2..255)
PC_W, 9, width of pc_4 path

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, asserted HIGH (active-high despite name)
EX_flush  in  1  load bubble into EX/MEM instead of EX values
EX_regwrite  in  1  EX control: register write
EX_memtoreg  in  1  EX control: writeback from memory
EX_memread  in  1  EX control: lw
EX_memwrite  in  1  EX control: sw
EX_link  in  1  EX control: jal
EX_wraddr  in  5  destination register
EX_alu_res  in  32  ALU result / memory byte address
EX_data2  in  32  forwarded rt value (store data)
EX_pc_4  in  PC_W  pc+4 for link
MEM_regwrite  out  1  to FWDPU
MEM_memread  out  1  to FWDPU
MEM_wraddr  out  5  to FWDPU
MEM_alu_res  out  32  to FWDPU forward path
mem_stall  out  1  to HZDPU: freeze PC, IF/ID, ID/EX, EX/MEM
dm_req  out  1  memory request
dm_we  out  1  1=write
dm_addr  out  30  word address (MEM_alu_res[31:2])
dm_wdata  out  32  store data
dm_rdata  in  32  load data, valid with dm_ack
dm_ack  in  1  access complete (may assert in the request cycle)
WB_regwrite  out  1  MEM/WB register write enable
WB_memtoreg  out  1
WB_link  out  1
WB_wraddr  out  5
WB_alu_res  out  32
WB_memdata  out  32
WB_pc_4  out  PC_W
mem_err  out  1  one-cycle pulse: misaligned access or timeout

Behaviour:
- Reset (rst_n=1 at edge): all EX/MEM and MEM/WB registers 0, FSM IDLE, count 0, mem_err 0, dm_req 0. Reset has priority over everything, including mid-access; dm_ack is ignored while rst_n=1 and in the cycle after.
- memop = MEM_memread | MEM_memwrite.
- misalign = memop & (MEM_alu_res[1:0] != 0).
- EX/MEM load, every edge where mem_stall=0:
  - EX_flush=1 -> bubble: all controls 0, data fields 0.
  - Otherwise capture the EX_* inputs.
  - mem_stall=1 -> hold, and EX_flush is ignored.
- FSM states:
  - IDLE: entered when a new EX/MEM value is loaded. If memop & ~misalign, dm_req=1 combinationally in the same cycle and the FSM moves to WAIT unless dm_ack=1 that cycle.
  - WAIT: dm_req=1, count increments each cycle. dm_ack -> IDLE (completed). count reaching TIMEOUT-1 with no ack -> IDLE (aborted). If ack and timeout coincide, ack wins.
  - A completed or aborted access is never reissued for the same EX/MEM contents; a done flag clears on the next EX/MEM load.
- dm_we = MEM_memwrite.
- dm_wdata = stored EX_data2.
- dm_addr = MEM_alu_res[31:2].
- mem_stall = dm_req & ~dm_ack & ~timeout_hit. Latency: zero-wait memory gives no stall; N-cycle ack gives N stall cycles.
- MEM/WB load, every edge:
  - If mem_stall=1 -> bubble: WB_regwrite=0, other fields don't-care but 0.
  - Else capture the MEM fields, WB_memdata=dm_rdata when memread completed with ack, otherwise 0.
- WB_regwrite is forced 0 when the instruction was misaligned or aborted.
- mem_err pulses one cycle in the cycle the misaligned instruction leaves MEM or the timeout fires.
- Misaligned op: no dm_req, no stall, no memory write.
- Non-memory instructions and bubbles pass in 1 cycle EX/MEM -> MEM/WB.

Test Plan:
- Reset: assert rst_n=1 for 2 cycles mid-WAIT -> dm_req=0, all WB_* = 0, mem_stall=0 next cycle.
- ALU pass-through: add with wraddr=5, alu_res=0x1234 -> two cycles later WB_regwrite=1, WB_wraddr=5, WB_alu_res=0x1234, mem_stall never 1.
- lw, zero-wait: addr 0x40, dm_ack in the request cycle, rdata=0xDEADBEEF -> dm_addr=0x10, no stall, next cycle WB_memdata=0xDEADBEEF, WB_memtoreg=1.
- sw, 3-cycle ack: addr 0x80, data 0xA5A5A5A5 -> dm_we=1, mem_stall high exactly 3 cycles, EX/MEM holds, single request only, WB_regwrite=0.
- Timeout: lw, no ack, TIMEOUT=16 -> stall 16 cycles, mem_err pulse, WB_regwrite=0, next instruction proceeds.
- Misaligned and flush: lw at 0x42 -> no dm_req, mem_err=1, WB_regwrite=0. EX_flush during stall is ignored; EX_flush otherwise yields a bubble.
